// File: rtl/t05_sram_pkg.sv
// t05_sram_pkg: shared FSM state type, default client base addresses and client ids for the SRAM arbiter.
package t05_sram_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

    localparam logic [127:0] T05_SRAM_BASES_DEFAULT = {32'd2048, 32'd1024, 32'd0, 32'd0};

    localparam int HIST_ID     = 0;
    localparam int FLV_ID      = 1;
    localparam int HTREE_ID    = 2;
    localparam int CODEBOOK_ID = 3;

    function automatic int rr_next(input int id, input int n);
        return (id + 1 == n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/t05_rr_arbiter.sv
// t05_rr_arbiter: combinational round-robin pick of the first requester at or after the pointer.
module t05_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);
    int w_j;
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!o_vld && i_req[w_j]) begin
                o_vld      = 1'b1;
                o_idx      = IW'(w_j);
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t05_sram_arbiter.sv
// t05_sram_arbiter: round-robin multi-client SRAM port with per-client base address and fixed wait states.
// Define T05_SRAM_ARB_BOUNDS_EN to add the per-client upper-bound check and the err output.
module t05_sram_arbiter
    import t05_sram_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int IDX_W       = 8,
    parameter int WAIT_CYCLES = 2,
    parameter logic [NUM_CLIENTS*ADDR_W-1:0] BASE_ADDRS = T05_SRAM_BASES_DEFAULT
`ifdef T05_SRAM_ARB_BOUNDS_EN
    ,
    parameter logic [NUM_CLIENTS*ADDR_W-1:0] LIMIT_ADDRS = {NUM_CLIENTS{{ADDR_W{1'b1}}}}
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        we,
    input  logic [NUM_CLIENTS*IDX_W-1:0]  idx,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]        ack,
    output logic [DATA_W-1:0]             rdata,
    output logic                          busy_o,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [DATA_W-1:0]             sram_wdata,
    input  logic [DATA_W-1:0]             sram_rdata,
    output logic                          sram_r_en,
    output logic                          sram_wr_en,
    output logic [DATA_W/8-1:0]           sram_sel
`ifdef T05_SRAM_ARB_BOUNDS_EN
    ,
    output logic                          err
`endif
);
    localparam int IW = $clog2(NUM_CLIENTS);

    arb_state_t              r_state, w_next;
    logic [IW-1:0]           r_id, r_ptr, w_gnt_idx;
    logic                    r_we, w_gnt_vld, w_oob;
    logic [3:0]              r_cnt;
    logic [ADDR_W-1:0]       r_addr, w_addr;
    logic [DATA_W-1:0]       r_wdata, r_rdata;
    logic [NUM_CLIENTS-1:0]  w_gnt;
`ifdef T05_SRAM_ARB_BOUNDS_EN
    logic                    r_err;
`endif

    t05_rr_arbiter #(.N(NUM_CLIENTS), .IW(IW)) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_vld (w_gnt_vld)
    );

    // Address wraps modulo 2^ADDR_W; overflow is silently dropped.
    always_comb begin
        w_addr = BASE_ADDRS[w_gnt_idx*ADDR_W +: ADDR_W] + ADDR_W'({idx[w_gnt_idx*IDX_W +: IDX_W], 2'b00});
`ifdef T05_SRAM_ARB_BOUNDS_EN
        w_oob  = w_addr >= LIMIT_ADDRS[w_gnt_idx*ADDR_W +: ADDR_W];
`else
        w_oob  = 1'b0;
`endif
        w_next = (r_state == IDLE)   ? (w_gnt_vld ? (w_oob ? DONE : ACCESS) : IDLE) :
                 (r_state == ACCESS) ? ((r_cnt == 4'd0) ? DONE : ACCESS) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
`ifdef T05_SRAM_ARB_BOUNDS_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_gnt_vld) begin
                r_id    <= w_gnt_idx;
                r_we    <= we[w_gnt_idx];
                r_addr  <= w_addr;
                r_wdata <= wdata[w_gnt_idx*DATA_W +: DATA_W];
                r_cnt   <= 4'(WAIT_CYCLES - 1);
                r_ptr   <= IW'(rr_next(int'(w_gnt_idx), NUM_CLIENTS));
`ifdef T05_SRAM_ARB_BOUNDS_EN
                r_err   <= w_oob;
                if (w_oob)
                    r_rdata <= '0;
`endif
            end
            if (r_state == ACCESS) begin
                if (r_cnt != 4'd0)
                    r_cnt <= r_cnt - 4'd1;
                else if (!r_we)
                    r_rdata <= sram_rdata;
            end
        end
    end

    // Strobes and ack decode straight from the state register so reset drops them at once.
    assign ack        = (r_state == DONE) ? (NUM_CLIENTS'(1) << r_id) : '0;
    assign rdata      = r_rdata;
    assign busy_o     = r_state != IDLE;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign sram_r_en  = (r_state == ACCESS) && !r_we;
    assign sram_wr_en = (r_state == ACCESS) && r_we;
    assign sram_sel   = (r_state == ACCESS) ? '1 : '0;
`ifdef T05_SRAM_ARB_BOUNDS_EN
    assign err        = (r_state == DONE) && r_err;
`endif

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// tb_t05_sram_arbiter: directed vector table plus hand sequences for contention, mid-op reset and bounds.
module tb_t05_sram_arbiter;
    localparam int N = 4, DW = 32, AW = 32, IW = 8, WC = 2;

    logic              clk = 1'b0, rst = 1'b1;
    logic [N-1:0]      req = '0, we = '0, ack;
    logic [N*IW-1:0]   idx = '0;
    logic [N*DW-1:0]   wdata = '0;
    logic [DW-1:0]     rdata, sram_wdata, sram_rdata = '0;
    logic [AW-1:0]     sram_addr;
    logic              busy_o, sram_r_en, sram_wr_en;
    logic [DW/8-1:0]   sram_sel;
`ifdef T05_SRAM_ARB_BOUNDS_EN
    logic              err;
`endif

    int total = 0, bad = 0, both_hi = 0, multi_ack = 0, sel_bad = 0;

    typedef struct {
        int          c;
        logic        w;
        logic [7:0]  ix;
        logic [31:0] wd;
        logic [31:0] srd;
        logic [31:0] ea;
        logic [31:0] er;
    } vec_t;
    vec_t vt[5];
    logic [3:0] rr_exp[5];

    t05_sram_arbiter #(
        .NUM_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW), .IDX_W(IW), .WAIT_CYCLES(WC),
        .BASE_ADDRS({32'd2048, 32'd1024, 32'hFFFFFFFC, 32'd0})
`ifdef T05_SRAM_ARB_BOUNDS_EN
        , .LIMIT_ADDRS({32'd3000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1024})
`endif
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .idx(idx), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy_o(busy_o), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_r_en(sram_r_en),
        .sram_wr_en(sram_wr_en), .sram_sel(sram_sel)
`ifdef T05_SRAM_ARB_BOUNDS_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sram_r_en && sram_wr_en) both_hi++;
        if ($countones(ack) > 1) multi_ack++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        logic [31:0] a_seen, w_seen;
        int rc, wc, lat;
        bit got;
        @(negedge clk);
        we[v.c] = v.w;
        idx[v.c*IW +: IW] = v.ix;
        wdata[v.c*DW +: DW] = v.wd;
        sram_rdata = v.srd;
        req = '0;
        req[v.c] = 1'b1;
        got = 0; lat = 0; rc = 0; wc = 0; a_seen = '0; w_seen = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (sram_r_en) rc++;
            if (sram_wr_en) wc++;
            if (sram_r_en || sram_wr_en) begin
                a_seen = sram_addr;
                w_seen = sram_wdata;
                if (sram_sel != 4'hF) sel_bad++;
            end
            if (ack != '0) begin
                got = 1;
                chk($sformatf("ack c%0d", v.c), 64'(ack), 64'(1) << v.c);
                req[v.c] = 1'b0;
            end
        end
        chk("ack seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), 64'(WC + 1));
        chk("r_en cycles", 64'(rc), v.w ? 64'd0 : 64'(WC));
        chk("wr_en cycles", 64'(wc), v.w ? 64'(WC) : 64'd0);
        chk("sram_addr", 64'(a_seen), 64'(v.ea));
        chk("rdata", 64'(rdata), 64'(v.er));
        if (v.w) chk("sram_wdata", 64'(w_seen), 64'(v.wd));
    endtask

    task automatic wait_ack(input string nm, input logic [3:0] exp);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                got = 1;
                chk(nm, 64'(ack), 64'(exp));
            end
        end
        if (!got) chk({nm, " timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int seen, last, lat, strb;
        vt[0] = '{2, 1'b0, 8'd5,   32'h0,        32'hDEADBEEF, 32'd1044,    32'hDEADBEEF};
        vt[1] = '{0, 1'b1, 8'd255, 32'h12345678, 32'h0,        32'd1020,    32'hDEADBEEF};
        vt[2] = '{1, 1'b0, 8'd1,   32'h0,        32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D};
        vt[3] = '{3, 1'b0, 8'd3,   32'h0,        32'h0BADC0DE, 32'd2060,    32'h0BADC0DE};
        vt[4] = '{3, 1'b1, 8'd0,   32'hA5A5A5A5, 32'h0,        32'd2048,    32'h0BADC0DE};
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        repeat (2) @(negedge clk);
        chk("rst ack", 64'(ack), 64'd0);
        chk("rst rdata", 64'(rdata), 64'd0);
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst strobes", 64'({sram_r_en, sram_wr_en, sram_sel}), 64'd0);
        chk("rst addr/wdata", 64'({sram_addr, sram_wdata}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(vt[i]);

        @(negedge clk);
        we = '0;
        req = 4'b1111;
        seen = 0; last = -1;
        for (int i = 0; i < 60 && seen < 5; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                chk($sformatf("rr ack %0d", seen), 64'(ack), 64'(rr_exp[seen]));
                if (last >= 0) chk("rr spacing", 64'(i - last), 64'(WC + 2));
                last = i;
                seen++;
                if (seen == 5) req = '0;
            end
        end
        chk("rr ack count", 64'(seen), 64'd5);

        @(negedge clk);
        idx[2*IW +: IW] = 8'd5;
        sram_rdata = 32'h55AA55AA;
        req = 4'b0100;
        @(negedge clk);
        chk("drop r_en", 64'(sram_r_en), 64'd1);
        req = 4'b0001;
        wait_ack("drop still acks", 4'b0100);
        chk("drop rdata", 64'(rdata), 64'h55AA55AA);
        wait_ack("ignored then served", 4'b0001);
        req = '0;

        @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        chk("pre-rst r_en", 64'(sram_r_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid-rst strobes", 64'({sram_r_en, sram_wr_en, sram_sel}), 64'd0);
        chk("mid-rst busy", 64'(busy_o), 64'd0);
        req = '0;
        strb = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack != '0) strb++;
        end
        chk("no ack under rst", 64'(strb), 64'd0);
        rst = 1'b0;
        req = 4'b1010;
        wait_ack("post-rst first", 4'b0010);
        req[1] = 1'b0;
        wait_ack("post-rst second", 4'b1000);
        req = '0;

`ifdef T05_SRAM_ARB_BOUNDS_EN
        run_txn('{0, 1'b0, 8'd200, 32'h0, 32'h11111111, 32'd800, 32'h11111111});
        chk("err in-bounds", 64'(err), 64'd0);
        @(negedge clk);
        we[3] = 1'b0;
        idx[3*IW +: IW] = 8'd255;
        req = 4'b1000;
        lat = 0; strb = 0; seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            lat++;
            if (sram_r_en || sram_wr_en) strb++;
            if (ack != '0) begin
                seen = 1;
                chk("oob ack", 64'(ack), 64'b1000);
                chk("oob err", 64'(err), 64'd1);
                chk("oob rdata", 64'(rdata), 64'd0);
                req = '0;
            end
        end
        chk("oob latency", 64'(lat), 64'd1);
        chk("oob strobes", 64'(strb), 64'd0);
        @(negedge clk);
        chk("err after done", 64'(err), 64'd0);
`endif

        chk("strobes exclusive", 64'(both_hi), 64'd0);
        chk("acks one-hot", 64'(multi_ack), 64'd0);
        chk("sel during access", 64'(sel_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
